// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator.
// The dead-time state type is used only when PWM_DEADTIME_EN is defined.
package pwm_pkg;

    localparam int         CW_DEFAULT     = 16;
    localparam logic [1:0] FUNC_LEFT      = 2'b00;
    localparam logic [1:0] FUNC_RIGHT     = 2'b01;
    localparam int         FUNC_RANGE_BIT = 1;

    typedef enum logic [1:0] {
        ACT_LO = 2'b00,
        ACT_HI = 2'b01,
        DEAD   = 2'b10
    } dt_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-band inserter: turns one PWM level into a complementary pair.
// Both outputs are low for dead_time cycles around every level change.
module pwm_deadtime
    import pwm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_en,
    input  logic       pwm_raw,
    input  logic [7:0] dead_time,
    output logic       pwm_out,
    output logic       pwm_out_n
);

    dt_state_e  state;
    dt_state_e  state_nxt;
    logic       target;
    logic       target_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    // A change of pwm_raw, including one during DEAD, restarts the dead band.
    // The counter holds the remaining DEAD cycles, so DEAD exits once it reaches 1.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        cnt_nxt    = cnt;
        if (pwm_raw != target) begin
            target_nxt = pwm_raw;
            if (dead_time == 8'd0) begin
                state_nxt = pwm_raw ? ACT_HI : ACT_LO;
                cnt_nxt   = 8'd0;
            end else begin
                state_nxt = DEAD;
                cnt_nxt   = dead_time;
            end
        end else if (state == DEAD) begin
            if (cnt <= 8'd1) begin
                state_nxt = target ? ACT_HI : ACT_LO;
                cnt_nxt   = 8'd0;
            end else begin
                cnt_nxt = cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !pwm_en) begin
            state     <= ACT_LO;
            target    <= 1'b0;
            cnt       <= 8'd0;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            cnt       <= cnt_nxt;
            pwm_out   <= (state_nxt == ACT_HI);
            pwm_out_n <= (state_nxt == ACT_LO);
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: compares the live counter value against double-buffered compare values.
// Optional macro PWM_DEADTIME_EN adds a complementary output with dead-band insertion.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_en,
    input  logic [CW-1:0] count_val,
    input  logic [CW-1:0] period,
    input  logic          upnotdown,
    input  logic [1:0]    functions,
    input  logic [CW-1:0] compare1,
    input  logic [CW-1:0] compare2,
`ifdef PWM_DEADTIME_EN
    input  logic [7:0]    dead_time,
    output logic          pwm_out_n,
`endif
    output logic          pwm_out,
    output logic          period_evt
);

    logic [CW-1:0] prev_cnt;
    logic [CW-1:0] cmp1_sh;
    logic [CW-1:0] cmp2_sh;
    logic [1:0]    func_sh;
    logic          wrap;
    logic [CW-1:0] eff_c1;
    logic [CW-1:0] eff_c2;
    logic [1:0]    eff_func;
    logic          raw;
    logic          pwm_raw;

    // Change detection keeps the event to one pulse however long the prescaler holds the count.
    assign wrap = (count_val != prev_cnt) &&
                  (upnotdown ? (count_val == '0) : (count_val == period));

    assign eff_c1   = wrap ? compare1  : cmp1_sh;
    assign eff_c2   = wrap ? compare2  : cmp2_sh;
    assign eff_func = wrap ? functions : func_sh;

    always_comb begin
        raw = 1'b0;
        if (eff_func[FUNC_RANGE_BIT]) begin
            raw = (eff_c1 < eff_c2) && (count_val >= eff_c1) && (count_val < eff_c2);
        end else if (eff_func == FUNC_RIGHT) begin
            raw = (count_val >= eff_c1);
        end else begin
            raw = (count_val < eff_c1);
        end
    end

    // While disabled the shadows track the inputs so enabling starts from fresh values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cnt   <= '0;
            cmp1_sh    <= '0;
            cmp2_sh    <= '0;
            func_sh    <= FUNC_LEFT;
            pwm_raw    <= 1'b0;
            period_evt <= 1'b0;
        end else begin
            prev_cnt <= count_val;
            if (!pwm_en || wrap) begin
                cmp1_sh <= compare1;
                cmp2_sh <= compare2;
                func_sh <= functions;
            end
            pwm_raw    <= pwm_en & raw;
            period_evt <= wrap & pwm_en;
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_deadtime u_deadtime (
        .clk       (clk),
        .rst       (rst),
        .pwm_en    (pwm_en),
        .pwm_raw   (pwm_raw),
        .dead_time (dead_time),
        .pwm_out   (pwm_out),
        .pwm_out_n (pwm_out_n)
    );
`else
    assign pwm_out = pwm_raw;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: the driver queues expected outputs, a monitor checks them.
// Build with PWM_DEADTIME_EN to also exercise the complementary dead-band outputs.
module tb_pwm_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_en = 1'b0;
    logic [15:0] count_val = '0;
    logic [15:0] period = '0;
    logic        upnotdown = 1'b1;
    logic [1:0]  functions = 2'b00;
    logic [15:0] compare1 = '0;
    logic [15:0] compare2 = '0;
    logic        pwm_out;
    logic        period_evt;
    logic        pwm_obs;
`ifdef PWM_DEADTIME_EN
    logic [7:0]  dead_time = 8'd0;
    logic        pwm_out_n;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string name;
        logic  pwm;
        logic  evt;
        logic  chk_dt;
        logic  out;
        logic  out_n;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pwm_gen #(.CW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_en     (pwm_en),
        .count_val  (count_val),
        .period     (period),
        .upnotdown  (upnotdown),
        .functions  (functions),
        .compare1   (compare1),
        .compare2   (compare2),
`ifdef PWM_DEADTIME_EN
        .dead_time  (dead_time),
        .pwm_out_n  (pwm_out_n),
`endif
        .pwm_out    (pwm_out),
        .period_evt (period_evt)
    );

    // With dead-band enabled, pwm_out is the FSM output, so the compare result is observed inside.
`ifdef PWM_DEADTIME_EN
    assign pwm_obs = dut.pwm_raw;
`else
    assign pwm_obs = pwm_out;
`endif

    task automatic applyStimulus(input string name, input int cnt, input bit exp_pwm,
                                 input bit exp_evt, input bit chk_dt = 1'b0,
                                 input bit exp_o = 1'b0, input bit exp_n = 1'b0);
        exp_t e;
        count_val = 16'(cnt);
        e.name   = name;
        e.pwm    = exp_pwm;
        e.evt    = exp_evt;
        e.chk_dt = chk_dt;
        e.out    = exp_o;
        e.out_n  = exp_n;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic checkOutput(input exp_t e);
        tests_run++;
        if (pwm_obs !== e.pwm) begin
            tests_failed++;
            $display("[TB] FAIL %s pwm actual=%0b expected=%0b count=%0d", e.name, pwm_obs, e.pwm, count_val);
        end
        tests_run++;
        if (period_evt !== e.evt) begin
            tests_failed++;
            $display("[TB] FAIL %s period_evt actual=%0b expected=%0b count=%0d", e.name, period_evt, e.evt, count_val);
        end
`ifdef PWM_DEADTIME_EN
        if (e.chk_dt) begin
            tests_run++;
            if (pwm_out !== e.out || pwm_out_n !== e.out_n) begin
                tests_failed++;
                $display("[TB] FAIL %s out/out_n actual=%0b/%0b expected=%0b/%0b", e.name, pwm_out, pwm_out_n, e.out, e.out_n);
            end
            tests_run++;
            if (pwm_out === 1'b1 && pwm_out_n === 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL %s overlap actual=both high expected=never", e.name);
            end
        end
`endif
    endtask

    // Every queued entry's output appears just after the rising edge that follows its drive.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        applyStimulus("reset", 0, 0, 0);
        applyStimulus("reset", 0, 0, 0);

        // Left-aligned 3/10 with a 9-period up counter.
        rst = 1'b0; period = 16'd9; compare1 = 16'd3; functions = 2'b00; upnotdown = 1'b1;
        applyStimulus("t1_setup", 0, 0, 0);
        pwm_en = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 10; c++)
                applyStimulus("t1_left", c, c < 3, c == 0 && p > 0);

        // Mid-period compare write takes effect only at the next wrap.
        for (int c = 0; c < 5; c++) applyStimulus("t2_old", c, c < 3, c == 0);
        compare1 = 16'd7;
        for (int c = 5; c < 10; c++) applyStimulus("t2_hold", c, 0, 0);
        for (int c = 0; c < 9; c++) applyStimulus("t2_new", c, c < 7, c == 0);

        functions = 2'b10; compare1 = 16'd2; compare2 = 16'd6;
        applyStimulus("t3_hold", 9, 0, 0);
        for (int c = 0; c < 10; c++) applyStimulus("t3_range", c, c >= 2 && c < 6, c == 0);
        for (int c = 0; c < 3; c++) applyStimulus("t3_range", c, c >= 2 && c < 6, c == 0);
        compare1 = 16'd6; compare2 = 16'd2;
        for (int c = 3; c < 10; c++) applyStimulus("t3_old", c, c >= 2 && c < 6, 0);
        for (int c = 0; c < 10; c++) applyStimulus("t3_inv", c, 0, c == 0);

        // Down counter, period 4, each value held three cycles.
        upnotdown = 1'b0; period = 16'd4; functions = 2'b00; compare1 = 16'd2;
        for (int r = 0; r < 2; r++)
            for (int v = 4; v >= 0; v--)
                for (int h = 0; h < 3; h++)
                    applyStimulus("t4_down", v, v < 2, v == 4 && h == 0);
        applyStimulus("t4_down", 4, 0, 1);

        pwm_en = 1'b0; upnotdown = 1'b1; period = 16'd9; compare1 = 16'd0;
        applyStimulus("t5_dis", 0, 0, 0);
        pwm_en = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 10; c++) applyStimulus("t5_left0", c, 0, c == 0 && p > 0);

        pwm_en = 1'b0; compare1 = 16'd10;
        applyStimulus("t5_dis", 0, 0, 0);
        pwm_en = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 10; c++) applyStimulus("t5_left100", c, 1, c == 0 && p > 0);

        pwm_en = 1'b0; functions = 2'b01; compare1 = 16'd0;
        applyStimulus("t5_dis_force", 0, 0, 0);
        pwm_en = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 10; c++) applyStimulus("t5_right0", c, 1, c == 0 && p > 0);

        // Reset during the high phase; shadows come back only at the next wrap.
        pwm_en = 1'b0; functions = 2'b00; compare1 = 16'd3;
        applyStimulus("t5_dis", 0, 0, 0);
        pwm_en = 1'b1;
        applyStimulus("t5_pre_rst", 0, 1, 0);
        applyStimulus("t5_pre_rst", 1, 1, 0);
        rst = 1'b1;
        applyStimulus("t5_rst", 2, 0, 0);
        rst = 1'b0;
        for (int c = 3; c < 10; c++) applyStimulus("t5_post_rst", c, 0, 0);
        for (int c = 0; c < 10; c++) applyStimulus("t5_reload", c, c < 3, c == 0);

`ifdef PWM_DEADTIME_EN
        pwm_en = 1'b0; dead_time = 8'd3; compare1 = 16'd5;
        applyStimulus("t6_dis", 0, 0, 0, 1, 0, 0);
        pwm_en = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 10; c++)
                applyStimulus("t6_dt3", c, c < 5, c == 0 && p > 0, 1,
                              c == 4 || c == 5, c == 0 || c == 9);

        pwm_en = 1'b0; dead_time = 8'd0;
        applyStimulus("t6_dis", 0, 0, 0, 1, 0, 0);
        pwm_en = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 10; c++)
                applyStimulus("t6_dt0", c, c < 5, c == 0 && p > 0, 1,
                              c >= 1 && c <= 5, !(c >= 1 && c <= 5));
`endif

        repeat (2) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain pending actual=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Consumer end of the timer counter: takes the live `count_val` stream from the counter and produces the PWM waveform.
- Compares the count against double-buffered compare registers.
- Shadow registers reload only at a counter wrap, so duty changes are glitch-free.
- Sits between the register file and the output pin logic, in parallel with the counter.

Parameters:
- CW, 16, counter/compare width; must match the counter's `count_val` width.

Ports:
- clk  input  1  peripheral clock
- rst  input  1  synchronous reset, active-high
- pwm_en  input  1  output enable
- count_val  input  CW  live counter value
- period  input  CW  counter period (same value the counter uses)
- upnotdown  input  1  counter direction, 1 = up
- functions  input  2  [1] 1 = range mode; [0] 0 = left-aligned, 1 = right-aligned (ignored in range mode)
- compare1  input  CW  compare value 1
- compare2  input  CW  compare value 2 (range mode only)
- pwm_out  output  1  PWM output, registered
- period_evt  output  1  one-cycle pulse on each detected counter wrap

Behaviour:
- All logic is clocked on posedge `clk`. When `rst`=1: `pwm_out`=0, `period_evt`=0, `prev_cnt`=0, shadows cmp1_sh/cmp2_sh/func_sh=0.
- `prev_cnt` registers `count_val` every cycle.
- Wrap event `wrap` is true when `count_val` != `prev_cnt` AND one of:
  - `upnotdown`=1 and `count_val`==0;
  - `upnotdown`=0 and `count_val`==`period`.
- Change detection makes the event fire once per wrap, regardless of prescale hold time.
- No event fires after reset while the count is held at 0.
- Shadow load rules:
  - `pwm_en`=0: shadows follow `compare1`/`compare2`/`functions` every cycle.
  - `pwm_en`=1: shadows load only on cycles where `wrap`=1.
- Effective values: eff = `wrap` ? inputs : shadows. The first count after a wrap therefore already uses the new values.
- Raw compare (combinational on `count_val` and eff), all comparisons unsigned CW-bit:
  - left (func=00): raw = `count_val` < eff_c1
  - right (func=01): raw = `count_val` >= eff_c1
  - range (func=1x): raw = (eff_c1 <= `count_val`) && (`count_val` < eff_c2); if eff_c1 >= eff_c2, raw = 0
- Output: `pwm_out` <= `pwm_en` & raw. Latency is 1 cycle from `count_val`.
- `pwm_en` deassert forces `pwm_out`=0 on the next edge.
- `period_evt` <= `wrap` & `pwm_en`, 1-cycle latency.
- Boundaries:
  - Left, c1=0: constant 0.
  - Left, c1>`period`: constant 1 (100%).
  - Right, c1=0: constant 1.
  - Direction change mid-period: evaluated purely on the current value; no event unless the wrap condition holds.
- Synchronous reset mid-period: outputs are 0 on the next edge; the first wrap after release loads new shadows.

Optional Feature:
- Macro `PWM_DEADTIME_EN`.
- When defined, adds ports:
  - `dead_time` input 8: dead-band length in clk cycles.
  - `pwm_out_n` output 1: complementary output.
- Registered `pwm_out` becomes the internal `pwm_raw`, which feeds a 3-state FSM:
  - States: ACT_HI (`pwm_out`=1, `pwm_out_n`=0), ACT_LO (0/1), DEAD (0/0).
  - Reset state: ACT_LO with both outputs 0 while `pwm_en`=0.
  - Any change of `pwm_raw` relative to the current target → DEAD, loading a down-counter with `dead_time`.
  - Counter reaches 0 → ACT_HI or ACT_LO per target.
  - `pwm_raw` toggling during DEAD retargets and reloads the counter.
  - `dead_time`=0 skips DEAD: plain complement, +1 cycle latency.
  - Falling edges are immediate; rising edges are delayed by `dead_time`+1 cycles.
  - `pwm_en`=0 forces both outputs to 0.
- When undefined: no extra ports; `pwm_out` is as in Behaviour.

Decomposition:
- Package `pwm_pkg`:
  - Constants: FUNC_LEFT=2'b00, FUNC_RIGHT=2'b01, FUNC_RANGE_BIT=1, default CW=16.
  - Dead-time FSM state enum: ACT_LO/ACT_HI/DEAD.
- One sub-module: `pwm_deadtime` (FSM plus 8-bit counter), instantiated only under `PWM_DEADTIME_EN`.

Test Plan:
1. Left, period=9, c1=3, up, en=1, prescale 0 → `pwm_out` high exactly for counts 0..2 (3 of 10 cycles), 1-cycle lag; `period_evt` once per 10 cycles.
2. Left c1=3, write c1=7 mid-period at count 5 → current period stays 3/10; next period is 7/10 starting with count 0.
3. Range c1=2, c2=6, period=9 → high for counts 2..5; then set c1=6, c2=2 → constant low from the next wrap.
4. Down count, period=4, prescale 2 → `period_evt` fires once per wrap to 4 (every 15 cycles), not while the count is held.
5. Boundaries: left c1=0 → always 0; left c1=10 with period=9 → always 1; `rst`=1 mid-high → `pwm_out`=0 next edge.
6. With `PWM_DEADTIME_EN`, dead_time=3, left c1=5 → `pwm_out` and `pwm_out_n` never high together; 3-cycle both-low gap at each transition; dead_time=0 → exact complements.
